s_word_packer: RTL
==================

# s_word_packer

Downstream consumer of the 3-bit `S` result bus of the registered XOR/NAND/OR result stage. Samples `S` on enabled cycles, packs four consecutive samples into a 12-bit word, and buffers completed words in a small FIFO with a valid/ready output handshake. Also keeps a saturating count of samples with `S[2]` set and a sticky overflow flag, for the test bench and for later scan/readout logic.

## Interface

Parameters:
- `DEPTH`, 2: number of FIFO word entries; legal values 2, 4, 8.
- `CNT_W`, 8: width of the `S[2]` event counter.

Ports:
- `CLK`  input  1  rising-edge clock; same clock as the upstream stage.
- `RST_N`  input  1  asynchronous, active-low reset.
- `EN`  input  1  sample enable; `S` is captured on a rising edge with `EN=1`.
- `S`  input  3  result bus from the upstream stage.
- `CLR`  input  1  synchronous clear of the counter, `OVF` and the partial word.
- `WORD`  output  12  head FIFO entry; first sample in `[2:0]`, fourth sample in `[11:9]`.
- `WVALID`  output  1  FIFO not empty.
- `WREADY`  input  1  consumer accepts `WORD` when `WVALID & WREADY`.
- `OVF`  output  1  sticky flag; a completed word was dropped because the FIFO was full.
- `S2_CNT`  output  CNT_W  saturating count of enabled samples with `S[2]=1`.

## Operation

- **Reset (`RST_N=0`, asynchronous)**
  - Slot index = 0; pack register = 0; FIFO empty.
  - `WVALID=0`, `WORD=0`, `OVF=0`, `S2_CNT=0`.
- **Packing**
  - A 2-bit slot index runs 0, 1, 2, 3 and wraps to 0.
  - On an enabled edge, `S` is written to bits `[3*slot+2 : 3*slot]` and the index advances.
  - On the edge that captures slot 3, the full word (the three stored samples plus the current `S`) is pushed into the FIFO on that same edge.
  - The pack register is not cleared between words; stale bits are overwritten slot by slot.
- **FIFO**
  - `DEPTH` entries with read/write pointers and an occupancy count.
  - Push on word completion; pop on `WVALID & WREADY`.
  - Push and pop on the same edge:
    - FIFO full: both are performed; occupancy is unchanged and no overflow occurs.
    - FIFO empty: no pop happens because `WVALID=0`, so only the push is performed.
  - Word completes while the FIFO is full and there is no pop: the word is dropped, `OVF` is set, and the slot index still wraps to 0.
  - `WORD` is driven from FIFO storage and is 0 while the FIFO is empty.
- **Counter**
  - `S2_CNT` increments on an enabled edge with `S[2]=1`.
  - It saturates at 2^CNT_W−1 and never wraps.
- **CLR**
  - Clears `S2_CNT`, `OVF`, the slot index and the pack register.
  - The sample presented in the `CLR` cycle is discarded (`CLR` has priority over `EN`).
  - The FIFO is not flushed, and a pop in the same cycle is still honoured.
- **Inactive cycles:** when `EN=0`, no state changes except FIFO pops.

## Timing

- All state changes on the rising edge of `CLK`, except the asynchronous reset.
- Latency: slot-3 capture at edge k gives `WVALID=1` and the new `WORD` after edge k, when the FIFO was empty. That is 1 cycle after the fourth sample, or 4 enabled edges after the first.
- `WVALID` and `WORD` are register outputs with no combinational path from `S`, `EN` or `WREADY`.
- Handshake: `WORD` and `WVALID` hold stable while `WVALID=1 & WREADY=0`. `WREADY` may be asserted with `WVALID=0`, which has no effect.
- Throughput: one word per 4 enabled cycles. The FIFO never fills if `WREADY` is high at least 1 cycle in 4.
- Reset asserted mid-word or with a full FIFO: all content is lost immediately. After `RST_N` deassertion, the first enabled edge captures into slot 0.
- `EN` gaps inside a word: the slot index holds and packing resumes at the same slot.

## Test plan

1. **Basic packing.** Reset, then `EN=1`, `WREADY=0`, and `S`=1,2,3,4 on consecutive edges.
   - Next cycle: `WVALID=1`, `WORD=12'h8D1` (bits `100_011_010_001`).
   - `S2_CNT=1`.
2. **Fill and overflow.** `DEPTH=2`, `WREADY=0`, 12 enabled samples.
   - Two words are held.
   - The third word is dropped and `OVF=1` after the 12th edge.
   - Then `WREADY=1`: the first two words are read in order, then `WVALID=0`.
3. **Push and pop on a full FIFO.** Full FIFO; `WREADY=1` on the same edge as a slot-3 capture.
   - No overflow; occupancy stays at `DEPTH`.
   - The new word is at the tail.
4. **Counter saturation.** `CNT_W=4`, `S=3'b100` for 20 enabled edges.
   - `S2_CNT=15`, held.
5. **CLR mid-word.** Two samples taken, then `CLR=1` with `EN=1` and `S=7`.
   - The next four samples 5,5,5,5 yield `WORD=12'hB6D`.
   - `S2_CNT` restarts from 0.
   - A FIFO entry present before `CLR` is preserved.
6. **Asynchronous reset.** `RST_N` pulled low between clock edges while `WVALID=1`.
   - `WVALID`, `WORD`, `OVF` and `S2_CNT` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/s_word_packer_if.sv
// Word stream handshake between the packer FIFO and its consumer.
interface s_word_packer_if;
    logic [11:0] word;
    logic        wvalid;
    logic        wready;

    modport master (output word, output wvalid, input wready);
    modport slave  (input word, input wvalid, output wready);
endinterface

// File: rtl/s_word_packer.sv
// Packs four enabled 3-bit S samples into a 12-bit word, buffers words in a
// small FIFO with a valid/ready output, and counts S[2] events (saturating).
module s_word_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       s,
    input  logic             clr,
    s_word_packer_if.master  wif,
    output logic             ovf,
    output logic [CNT_W-1:0] s2_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [1:0]    slot_q;
    logic [11:0]   pack_q;
    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [11:0]   word_q;
    logic          wvalid_q;

    logic          push_word, pop, full, do_push;
    logic [11:0]   new_word;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count_next;
    logic [11:0]   head_next;

    always_comb begin
        push_word  = en && !clr && (slot_q == 2'd3);
        new_word   = {s, pack_q[8:0]};
        pop        = wvalid_q && wif.wready;
        full       = (count_q == DEPTH_C);
        do_push    = push_word && (!full || pop);
        rd_next    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_next = count_q;
        if (do_push && !pop)
            count_next = count_q + 1'b1;
        else if (!do_push && pop)
            count_next = count_q - 1'b1;
        // The head of the next cycle may be the very entry written on this edge.
        head_next = 12'h000;
        if (count_next != '0) begin
            if (do_push && (rd_next == wr_ptr_q))
                head_next = new_word;
            else
                head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= new_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= 2'd0;
            pack_q   <= 12'h000;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            word_q   <= 12'h000;
            wvalid_q <= 1'b0;
            ovf      <= 1'b0;
            s2_cnt   <= '0;
        end else begin
            if (clr) begin
                slot_q <= 2'd0;
                pack_q <= 12'h000;
            end else if (en) begin
                slot_q <= slot_q + 2'd1;
                for (int i = 0; i < 4; i++) begin
                    if (slot_q == i[1:0])
                        pack_q[3*i +: 3] <= s;
                end
            end

            if (clr)
                s2_cnt <= '0;
            else if (en && s[2] && !(&s2_cnt))
                s2_cnt <= s2_cnt + 1'b1;

            if (clr)
                ovf <= 1'b0;
            else if (push_word && !do_push)
                ovf <= 1'b1;

            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            rd_ptr_q <= rd_next;
            count_q  <= count_next;
            word_q   <= head_next;
            wvalid_q <= (count_next != '0);
        end
    end

    assign wif.word   = word_q;
    assign wif.wvalid = wvalid_q;
endmodule
